// File: rtl/div_iter_if.sv
// Divide handshake between the execute-stage ALU (master) and the
// iterative divider (slave). Signal suffixes are from the divider's side.
interface div_iter_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit divider, restoring radix-2, one quotient bit per cycle.
// Returns {remainder, quotient} for the HI/LO write. Signed operands are
// converted to magnitudes on entry and the signs are re-applied at the end.
module div_iter (
    input  logic      clk,
    input  logic      rst,
    div_iter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_END  = 2'd2
    } state_t;

    // Two's-complement negate, modulo 2^32.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Negate only when the flag is set.
    function automatic logic [31:0] cond_neg32(input logic flag, input logic [31:0] v);
        if (flag) begin
            return neg32(v);
        end else begin
            return v;
        end
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;     // {partial remainder, dividend/quotient}
    logic [31:0] dvs_q, dvs_d;       // divisor magnitude
    logic        qneg_q, qneg_d;     // quotient needs negation
    logic        rneg_q, rneg_d;     // remainder needs negation
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] trial_s;
    logic        borrow_s;
    logic [31:0] diff_s;
    logic [63:0] work_step_s;

    // One restoring step: shift left, trial-subtract divisor from the top 33 bits.
    always_comb begin
        trial_s  = work_q[63:31];
        borrow_s = (trial_s < {1'b0, dvs_q});
        // When there is no borrow the difference is below the divisor, so 32 bits suffice.
        diff_s   = trial_s[31:0] - dvs_q;
        if (borrow_s) begin
            work_step_s = {trial_s[31:0], work_q[30:0], 1'b0};
        end else begin
            work_step_s = {diff_s, work_q[30:0], 1'b1};
        end
    end

    // Next-state and datapath/output next values; annul has top priority.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else if (bus.start_i) begin
                    if (bus.opdata2_i == 32'd0) begin
                        // Divide by zero: answer immediately with zero.
                        result_d = 64'd0;
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end else begin
                        work_d  = {32'd0, cond_neg32(bus.signed_div_i & bus.opdata1_i[31], bus.opdata1_i)};
                        dvs_d   = cond_neg32(bus.signed_div_i & bus.opdata2_i[31], bus.opdata2_i);
                        qneg_d  = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        rneg_d  = bus.signed_div_i & bus.opdata1_i[31];
                        cnt_d   = 6'd0;
                        state_d = S_ON;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = work_step_s;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_d = {cond_neg32(rneg_q, work_step_s[63:32]),
                                    cond_neg32(qneg_q, work_step_s[31:0])};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end else begin
                        state_d = S_ON;
                    end
                end
            end
            S_END: begin
                // Hold the result until the ALU drops start; no restart before that.
                if (bus.annul_i || !bus.start_i) begin
                    state_d = S_IDLE;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_END;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            work_q   <= 64'd0;
            dvs_q    <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter with a scoreboard queue of expected results.
module tb_div_iter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_iter_if dif ();

    div_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp);
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        sb_q.push_back(exp);
    endtask

    // Counts edges from E0 until ready_o is seen (E0 itself is edge 1).
    task automatic wait_ready(input string tag, input int exp_edges, input bit toggle);
        int          n;
        logic [63:0] exp;
        n = 0;
        do begin
            tick();
            n++;
            if (toggle) begin
                dif.opdata1_i    = $urandom;
                dif.opdata2_i    = $urandom;
                dif.signed_div_i = ~dif.signed_div_i;
            end
        end while (dif.ready_o !== 1'b1 && n < 40);
        chk({tag, " latency"}, 64'(n), 64'(exp_edges));
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
        end else begin
            exp = 64'hDEAD_DEAD_DEAD_DEAD;
        end
        chk({tag, " result"}, dif.result_o, exp);
        last_res = exp;
    endtask

    task automatic release_req(input string tag);
        dif.start_i = 1'b0;
        tick();
        chk({tag, " ready drop"}, {63'd0, dif.ready_o}, 64'd0);
        chk({tag, " result hold"}, dif.result_o, last_res);
    endtask

    initial begin
        int          n_ready;
        logic [31:0] ra, rb;

        rst              = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd0;
        dif.opdata2_i    = 32'd0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        last_res         = 64'd0;

        // Reset state
        repeat (3) tick();
        chk("reset ready", {63'd0, dif.ready_o}, 64'd0);
        chk("reset result", dif.result_o, 64'd0);
        rst = 1'b1;
        repeat (2) tick();
        chk("idle ready", {63'd0, dif.ready_o}, 64'd0);

        // Unsigned 100 / 7, then hold start for 3 more cycles
        drive_req(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        wait_ready("divu 100/7", 33, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold ready", {63'd0, dif.ready_o}, 64'd1);
            chk("hold result", dif.result_o, last_res);
        end
        release_req("divu 100/7");

        // Signed and corner cases, back to back with one idle cycle between
        drive_req(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        wait_ready("div -7/2", 33, 1'b0);
        release_req("div -7/2");

        drive_req(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        wait_ready("div 7/-2", 33, 1'b0);
        release_req("div 7/-2");

        drive_req(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        wait_ready("div min/-1", 33, 1'b0);
        release_req("div min/-1");

        drive_req(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF);
        wait_ready("divu max/16", 33, 1'b0);
        release_req("divu max/16");

        // Divide by zero answers right after E0, then a normal request
        drive_req(1'b1, 32'd1234, 32'd0, 64'd0);
        wait_ready("div by zero", 1, 1'b0);
        release_req("div by zero");

        drive_req(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        wait_ready("after zero", 33, 1'b0);
        release_req("after zero");

        // Annul at E10: nothing produced, result keeps prior value
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        tick();                        // E0
        repeat (9) tick();             // E1..E9
        dif.annul_i = 1'b1;
        dif.start_i = 1'b0;
        tick();                        // E10
        dif.annul_i = 1'b0;
        n_ready = 0;
        for (int i = 0; i < 35; i++) begin
            if (dif.ready_o === 1'b1) n_ready++;
            tick();
        end
        chk("annul no ready", 64'(n_ready), 64'd0);
        chk("annul result hold", dif.result_o, last_res);

        drive_req(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);
        wait_ready("after annul", 33, 1'b0);
        release_req("after annul");

        // Operand and signedness changes during ON are ignored
        drive_req(1'b0, 32'd1000, 32'd33, 64'h0000000A_0000001E);
        wait_ready("toggle ops", 33, 1'b1);
        release_req("toggle ops");

        // A few random unsigned divides against a reference model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = 32'($urandom_range(1, 100000));
            drive_req(1'b0, ra, rb, {ra % rb, ra / rb});
            wait_ready("divu random", 33, 1'b0);
            release_req("divu random");
        end

        // Asynchronous reset in the middle of ON
        drive_req(1'b0, 32'd100, 32'd7, 64'd0);
        void'(sb_q.pop_back());
        tick();                        // E0
        repeat (5) tick();
        #3;
        rst = 1'b0;
        #1;
        chk("async rst ready", {63'd0, dif.ready_o}, 64'd0);
        chk("async rst result", dif.result_o, 64'd0);
        dif.start_i = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        n_ready = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dif.ready_o === 1'b1) n_ready++;
        end
        chk("post rst no ready", 64'(n_ready), 64'd0);
        chk("post rst result", dif.result_o, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit divider: the responder end of the ALU's divide handshake (`start_i`/`ready_o`). The execute-stage ALU raises `start_i` with operands and signedness for DIV/DIVU and stalls while `ready_o` is low. This block computes the quotient and remainder with a restoring radix-2 algorithm at one bit per cycle. It returns `{remainder, quotient}` for the HI/LO write.

## Interface
- No parameters; data width is fixed at 32.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-low (0 = reset)
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`
- `opdata1_i`  in  32  dividend; sampled with `start_i`
- `opdata2_i`  in  32  divisor; sampled with `start_i`
- `start_i`  in  1  request; level, held high by the ALU until it sees `ready_o`
- `annul_i`  in  1  abort the current operation (pipeline flush)
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`; registered
- `ready_o`  out  1  result valid; registered

## Operation
- States: IDLE, ON, END.
- **IDLE**
  - `start_i`=1, `annul_i`=0, divisor ≠ 0: latch the operand magnitudes (two's-complement negate negatives when `signed_div_i`=1), latch the sign flags, clear the 6-bit iteration counter, go to ON.
  - `start_i`=1, `annul_i`=0, divisor = 0: load `result_o` = 0, go directly to END.
  - Otherwise stay in IDLE.
- **ON**, each cycle:
  - Shift the 64-bit working register {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If there is no borrow, keep the difference and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - Counter +1.
  - After iteration 32 (counter = 31 at the edge): apply signs, register `result_o`, go to END.
- **Sign fix-up**
  - Quotient is negated if `signed_div_i` and the operand signs differ.
  - Remainder is negated if `signed_div_i` and the dividend is negative.
  - All arithmetic is modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- **END**
  - `ready_o`=1; `result_o` held stable.
  - `start_i`=0: go to IDLE.
  - `start_i`=1: stay in END; no restart until `start_i` has dropped for at least one cycle.
- **annul_i**
  - Highest priority in every state.
  - ON or END: go to IDLE at the next edge, `ready_o`→0, `result_o` keeps its previous value.
  - IDLE: suppresses start.
- Operand or `signed_div_i` changes after the sampling edge are ignored.

## Timing
- Reset (`rst`=0, asynchronous): state = IDLE, `ready_o`=0, `result_o`=0, counter = 0, working registers = 0. Reset during ON or END discards the operation. After release the block idles until it sees `start_i`.
- Edge numbering: E0 is the edge that samples `start_i` in IDLE.
- Normal latency: ON covers E1..E32 (32 iterations). `result_o` and `ready_o` update at E32 and are visible in the cycle after E32.
- Divide-by-zero latency: `ready_o`=1 and `result_o`=0 are visible after E0.
- `ready_o` drops at the first edge that samples `start_i`=0 in END. Minimum back-to-back spacing is one IDLE cycle between requests.
- `ready_o` is never high in IDLE or ON. The `result_o` update and the `ready_o` rise happen at the same edge.

## Test plan
- **Unsigned divide.** DIVU 100 / 7.
  - `ready_o` rises exactly 32 edges after E0.
  - `result_o` = 0x00000002_0000000E.
  - Holding `start_i` for 3 more cycles keeps `ready_o`=1 with a stable result; dropping `start_i` clears `ready_o` at the next edge.
- **Signed divide.**
  - DIV −7 / 2: `result_o` = 0xFFFFFFFF_FFFFFFFD.
  - DIV 7 / −2: `result_o` = 0x00000001_FFFFFFFD.
  - DIV 0x80000000 / 0xFFFFFFFF: `result_o` = 0x00000000_80000000.
  - DIVU 0xFFFFFFFF / 0x10: `result_o` = 0x0000000F_0FFFFFFF.
- **Divide by zero.** DIV 1234 / 0: `ready_o`=1 after E0 with `result_o`=0. The next request afterwards completes normally.
- **Annul.** Start DIVU 100 / 7, pulse `annul_i` at E10.
  - `ready_o` stays 0 and `result_o` keeps its prior value.
  - Block is in IDLE; a new DIVU 9 / 3 gives 0x00000000_00000003 with full 32-edge latency.
- **Reset.**
  - Drive `rst` low asynchronously mid-cycle during ON: `ready_o` and `result_o` go to 0 immediately.
  - With `start_i` held low, no `ready_o` appears after release.
- **Back-to-back and operand stability.**
  - Two requests with a one-cycle `start_i`=0 gap both produce correct results.
  - Toggling `opdata1_i`/`opdata2_i` during ON does not change the result.
